ddr_axi_rr_arbiter: RTL and testbench

Two-master to one-slave AXI4 arbiter that shares the single DDR-C port (cl_sh_ddr) between the host DMA-PCIS path (master 0) and the Fletcher accelerator master (master 1).
- AR and AW are arbitrated independently by round-robin.
- The master index is tagged onto the MSB of the ID; R and B responses are routed back by that bit.
- W beats are ordered by a write-order FIFO.
- Sits between cl_dma_pcis_slv's interconnect outputs and the DDR interface wiring.

---
 rtl/ddr_axi_rr_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_ddr_axi_rr_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_axi_rr_arbiter.sv
// Two-master to one-slave AXI4 arbiter for the shared DDR-C port.
// AR/AW are round-robin arbitrated; the master index rides in the ID MSB and steers R/B back.
module ddr_axi_rr_arbiter #(
   parameter int ADDR_WIDTH  = 64,
   parameter int DATA_WIDTH  = 512,
   parameter int ID_WIDTH    = 6,
   parameter int WFIFO_DEPTH = 4
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   // master 0 (host DMA-PCIS)
   input  logic                    s0_arvalid,
   output logic                    s0_arready,
   input  logic [ADDR_WIDTH-1:0]   s0_araddr,
   input  logic [ID_WIDTH-1:0]     s0_arid,
   input  logic [7:0]              s0_arlen,
   input  logic [2:0]              s0_arsize,
   output logic                    s0_rvalid,
   input  logic                    s0_rready,
   output logic [DATA_WIDTH-1:0]   s0_rdata,
   output logic [ID_WIDTH-1:0]     s0_rid,
   output logic [1:0]              s0_rresp,
   output logic                    s0_rlast,
   input  logic                    s0_awvalid,
   output logic                    s0_awready,
   input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
   input  logic [ID_WIDTH-1:0]     s0_awid,
   input  logic [7:0]              s0_awlen,
   input  logic [2:0]              s0_awsize,
   input  logic                    s0_wvalid,
   output logic                    s0_wready,
   input  logic [DATA_WIDTH-1:0]   s0_wdata,
   input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
   input  logic                    s0_wlast,
   output logic                    s0_bvalid,
   input  logic                    s0_bready,
   output logic [ID_WIDTH-1:0]     s0_bid,
   output logic [1:0]              s0_bresp,
   // master 1 (Fletcher)
   input  logic                    s1_arvalid,
   output logic                    s1_arready,
   input  logic [ADDR_WIDTH-1:0]   s1_araddr,
   input  logic [ID_WIDTH-1:0]     s1_arid,
   input  logic [7:0]              s1_arlen,
   input  logic [2:0]              s1_arsize,
   output logic                    s1_rvalid,
   input  logic                    s1_rready,
   output logic [DATA_WIDTH-1:0]   s1_rdata,
   output logic [ID_WIDTH-1:0]     s1_rid,
   output logic [1:0]              s1_rresp,
   output logic                    s1_rlast,
   input  logic                    s1_awvalid,
   output logic                    s1_awready,
   input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
   input  logic [ID_WIDTH-1:0]     s1_awid,
   input  logic [7:0]              s1_awlen,
   input  logic [2:0]              s1_awsize,
   input  logic                    s1_wvalid,
   output logic                    s1_wready,
   input  logic [DATA_WIDTH-1:0]   s1_wdata,
   input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
   input  logic                    s1_wlast,
   output logic                    s1_bvalid,
   input  logic                    s1_bready,
   output logic [ID_WIDTH-1:0]     s1_bid,
   output logic [1:0]              s1_bresp,
   // slave side towards DDR
   output logic                    m_arvalid,
   input  logic                    m_arready,
   output logic [ADDR_WIDTH-1:0]   m_araddr,
   output logic [ID_WIDTH:0]       m_arid,
   output logic [7:0]              m_arlen,
   output logic [2:0]              m_arsize,
   input  logic                    m_rvalid,
   output logic                    m_rready,
   input  logic [DATA_WIDTH-1:0]   m_rdata,
   input  logic [ID_WIDTH:0]       m_rid,
   input  logic [1:0]              m_rresp,
   input  logic                    m_rlast,
   output logic                    m_awvalid,
   input  logic                    m_awready,
   output logic [ADDR_WIDTH-1:0]   m_awaddr,
   output logic [ID_WIDTH:0]       m_awid,
   output logic [7:0]              m_awlen,
   output logic [2:0]              m_awsize,
   output logic                    m_wvalid,
   input  logic                    m_wready,
   output logic [DATA_WIDTH-1:0]   m_wdata,
   output logic [DATA_WIDTH/8-1:0] m_wstrb,
   output logic                    m_wlast,
   input  logic                    m_bvalid,
   output logic                    m_bready,
   input  logic [ID_WIDTH:0]       m_bid,
   input  logic [1:0]              m_bresp
);

   localparam int PW = $clog2(WFIFO_DEPTH);
   localparam int CW = $clog2(WFIFO_DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(WFIFO_DEPTH);

   logic ar_prio, ar_lock, ar_gnt, ar_sel;
   logic aw_prio, aw_lock, aw_gnt, aw_sel;
   logic [WFIFO_DEPTH-1:0] wf_mem;
   logic [PW-1:0]          wf_wr, wf_rd;
   logic [CW-1:0]          wf_count;
   logic wf_full, wf_push, wf_pop, w_head, w_any, r_own, b_own;

   // A locked grant holds the presented master until its handshake.
   always_comb begin
      ar_sel = s1_arvalid;
      if (ar_lock) ar_sel = ar_gnt;
      else if (s0_arvalid && s1_arvalid) ar_sel = ar_prio;
      aw_sel = s1_awvalid;
      if (aw_lock) aw_sel = aw_gnt;
      else if (s0_awvalid && s1_awvalid) aw_sel = aw_prio;
   end

   assign m_arvalid  = aresetn & (ar_sel ? s1_arvalid : s0_arvalid);
   assign m_araddr   = ar_sel ? s1_araddr : s0_araddr;
   assign m_arid     = {ar_sel, (ar_sel ? s1_arid : s0_arid)};
   assign m_arlen    = ar_sel ? s1_arlen : s0_arlen;
   assign m_arsize   = ar_sel ? s1_arsize : s0_arsize;
   assign s0_arready = m_arvalid & m_arready & ~ar_sel;
   assign s1_arready = m_arvalid & m_arready & ar_sel;

   // The full gate looks at the registered count, so a same-cycle pop does not free a slot.
   assign wf_full    = (wf_count == FULL_CNT);
   assign m_awvalid  = aresetn & ~wf_full & (aw_sel ? s1_awvalid : s0_awvalid);
   assign m_awaddr   = aw_sel ? s1_awaddr : s0_awaddr;
   assign m_awid     = {aw_sel, (aw_sel ? s1_awid : s0_awid)};
   assign m_awlen    = aw_sel ? s1_awlen : s0_awlen;
   assign m_awsize   = aw_sel ? s1_awsize : s0_awsize;
   assign s0_awready = m_awvalid & m_awready & ~aw_sel;
   assign s1_awready = m_awvalid & m_awready & aw_sel;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         ar_prio <= 1'b0;
         ar_lock <= 1'b0;
         ar_gnt  <= 1'b0;
         aw_prio <= 1'b0;
         aw_lock <= 1'b0;
         aw_gnt  <= 1'b0;
      end else begin
         if (m_arvalid && m_arready) begin
            ar_lock <= 1'b0;
            ar_prio <= ~ar_sel;
         end else if (m_arvalid) begin
            ar_lock <= 1'b1;
            ar_gnt  <= ar_sel;
         end
         if (m_awvalid && m_awready) begin
            aw_lock <= 1'b0;
            aw_prio <= ~aw_sel;
         end else if (m_awvalid) begin
            aw_lock <= 1'b1;
            aw_gnt  <= aw_sel;
         end
      end
   end

   // Write-order FIFO: one entry per accepted AW, holding the owning master index.
   assign wf_push = m_awvalid & m_awready;
   assign wf_pop  = m_wvalid & m_wready & m_wlast;
   assign w_head  = wf_mem[wf_rd];
   assign w_any   = (wf_count != '0);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wf_wr    <= '0;
         wf_rd    <= '0;
         wf_count <= '0;
      end else begin
         if (wf_push) wf_wr <= wf_wr + 1'b1;
         if (wf_pop)  wf_rd <= wf_rd + 1'b1;
         if (wf_push && !wf_pop)      wf_count <= wf_count + 1'b1;
         else if (wf_pop && !wf_push) wf_count <= wf_count - 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (wf_push) wf_mem[wf_wr] <= aw_sel;
   end

   assign m_wvalid  = aresetn & w_any & (w_head ? s1_wvalid : s0_wvalid);
   assign m_wdata   = w_head ? s1_wdata : s0_wdata;
   assign m_wstrb   = w_head ? s1_wstrb : s0_wstrb;
   assign m_wlast   = w_head ? s1_wlast : s0_wlast;
   assign s0_wready = w_any & ~w_head & m_wready;
   assign s1_wready = w_any & w_head & m_wready;

   assign r_own     = m_rid[ID_WIDTH];
   assign s0_rvalid = aresetn & m_rvalid & ~r_own;
   assign s1_rvalid = aresetn & m_rvalid & r_own;
   assign m_rready  = r_own ? s1_rready : s0_rready;
   assign s0_rid    = m_rid[ID_WIDTH-1:0];
   assign s1_rid    = m_rid[ID_WIDTH-1:0];
   assign s0_rdata  = m_rdata;
   assign s1_rdata  = m_rdata;
   assign s0_rresp  = m_rresp;
   assign s1_rresp  = m_rresp;
   assign s0_rlast  = m_rlast;
   assign s1_rlast  = m_rlast;

   assign b_own     = m_bid[ID_WIDTH];
   assign s0_bvalid = aresetn & m_bvalid & ~b_own;
   assign s1_bvalid = aresetn & m_bvalid & b_own;
   assign m_bready  = b_own ? s1_bready : s0_bready;
   assign s0_bid    = m_bid[ID_WIDTH-1:0];
   assign s1_bid    = m_bid[ID_WIDTH-1:0];
   assign s0_bresp  = m_bresp;
   assign s1_bresp  = m_bresp;

endmodule

// File: tb/tb_ddr_axi_rr_arbiter.sv
// Bench for ddr_axi_rr_arbiter: routing table, directed multi-cycle sequences,
// and randomized AR/R/B traffic against a transaction-level model.
module tb_ddr_axi_rr_arbiter;

   localparam int AW = 64;
   localparam int DW = 512;
   localparam int IW = 6;

   logic clk = 1'b0;
   logic aresetn;
   always #5 clk = ~clk;

   logic s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast, s0_awvalid, s0_awready;
   logic s0_wvalid, s0_wready, s0_wlast, s0_bvalid, s0_bready;
   logic [AW-1:0] s0_araddr, s0_awaddr;
   logic [IW-1:0] s0_arid, s0_rid, s0_awid, s0_bid;
   logic [7:0] s0_arlen, s0_awlen;
   logic [2:0] s0_arsize, s0_awsize;
   logic [1:0] s0_rresp, s0_bresp;
   logic [DW-1:0] s0_rdata, s0_wdata;
   logic [DW/8-1:0] s0_wstrb;

   logic s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast, s1_awvalid, s1_awready;
   logic s1_wvalid, s1_wready, s1_wlast, s1_bvalid, s1_bready;
   logic [AW-1:0] s1_araddr, s1_awaddr;
   logic [IW-1:0] s1_arid, s1_rid, s1_awid, s1_bid;
   logic [7:0] s1_arlen, s1_awlen;
   logic [2:0] s1_arsize, s1_awsize;
   logic [1:0] s1_rresp, s1_bresp;
   logic [DW-1:0] s1_rdata, s1_wdata;
   logic [DW/8-1:0] s1_wstrb;

   logic m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, m_awvalid, m_awready;
   logic m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
   logic [AW-1:0] m_araddr, m_awaddr;
   logic [IW:0] m_arid, m_rid, m_awid, m_bid;
   logic [7:0] m_arlen, m_awlen;
   logic [2:0] m_arsize, m_awsize;
   logic [1:0] m_rresp, m_bresp;
   logic [DW-1:0] m_rdata, m_wdata;
   logic [DW/8-1:0] m_wstrb;

   ddr_axi_rr_arbiter dut (
      .aclk(clk), .aresetn(aresetn),
      .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr), .s0_arid(s0_arid),
      .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
      .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rid(s0_rid),
      .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
      .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awaddr(s0_awaddr), .s0_awid(s0_awid),
      .s0_awlen(s0_awlen), .s0_awsize(s0_awsize),
      .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
      .s0_wlast(s0_wlast),
      .s0_bvalid(s0_bvalid), .s0_bready(s0_bready), .s0_bid(s0_bid), .s0_bresp(s0_bresp),
      .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr), .s1_arid(s1_arid),
      .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
      .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rid(s1_rid),
      .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
      .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_awaddr(s1_awaddr), .s1_awid(s1_awid),
      .s1_awlen(s1_awlen), .s1_awsize(s1_awsize),
      .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
      .s1_wlast(s1_wlast),
      .s1_bvalid(s1_bvalid), .s1_bready(s1_bready), .s1_bid(s1_bid), .s1_bresp(s1_bresp),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
      .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid),
      .m_rresp(m_rresp), .m_rlast(m_rlast),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
      .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_wlast(m_wlast),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp)
   );

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      s0_arvalid = 0; s0_araddr = '0; s0_arid = '0; s0_arlen = '0; s0_arsize = '0; s0_rready = 0;
      s0_awvalid = 0; s0_awaddr = '0; s0_awid = '0; s0_awlen = '0; s0_awsize = '0;
      s0_wvalid = 0; s0_wdata = '0; s0_wstrb = '0; s0_wlast = 0; s0_bready = 0;
      s1_arvalid = 0; s1_araddr = '0; s1_arid = '0; s1_arlen = '0; s1_arsize = '0; s1_rready = 0;
      s1_awvalid = 0; s1_awaddr = '0; s1_awid = '0; s1_awlen = '0; s1_awsize = '0;
      s1_wvalid = 0; s1_wdata = '0; s1_wstrb = '0; s1_wlast = 0; s1_bready = 0;
      m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rid = '0; m_rresp = '0; m_rlast = 0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_bid = '0; m_bresp = '0;
   endtask

   typedef struct {
      logic       valid;
      logic [6:0] id;
      logic       rdy0;
      logic       rdy1;
      logic       e_v0;
      logic       e_v1;
      logic [5:0] e_id;
      logic       e_mrdy;
   } route_vec_t;

   route_vec_t tbl[6];

   localparam logic [63:0] A0 = 64'h0000_0000_1000_0000;
   localparam logic [63:0] A1 = 64'h0000_0000_2000_0000;

   // model state for the randomized AR phase
   bit          act[2];
   logic [63:0] raddr[2];
   logic [5:0]  rid_q[2];
   int          last_served, committed, win;
   logic [6:0]  rnd_id;

   initial begin
      tbl[0] = '{1'b1, 7'h41, 1'b0, 1'b1, 1'b0, 1'b1, 6'h01, 1'b1};
      tbl[1] = '{1'b1, 7'h05, 1'b1, 1'b0, 1'b1, 1'b0, 6'h05, 1'b1};
      tbl[2] = '{1'b1, 7'h41, 1'b1, 1'b0, 1'b0, 1'b1, 6'h01, 1'b0};
      tbl[3] = '{1'b1, 7'h05, 1'b0, 1'b1, 1'b1, 1'b0, 6'h05, 1'b0};
      tbl[4] = '{1'b0, 7'h7f, 1'b1, 1'b1, 1'b0, 1'b0, 6'h3f, 1'b1};
      tbl[5] = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0};

      // reset: valids forced low while aresetn is asserted
      idle();
      aresetn = 0;
      s0_arvalid = 1; s0_awvalid = 1; m_rvalid = 1; m_bvalid = 1;
      settle();
      chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
      chk("rst_m_awvalid", 64'(m_awvalid), 64'd0);
      chk("rst_s0_rvalid", 64'(s0_rvalid), 64'd0);
      chk("rst_s0_bvalid", 64'(s0_bvalid), 64'd0);
      step(); step();
      aresetn = 1;
      idle();

      // 1: continuous requests from both alternate starting with master 0
      s0_arvalid = 1; s0_araddr = A0; s1_arvalid = 1; s1_araddr = A1; m_arready = 1;
      for (int i = 0; i < 6; i++) begin
         settle();
         chk("rr_arid_msb", 64'(m_arid[6]), 64'(i % 2));
         chk("rr_araddr", m_araddr, (i % 2) ? A1 : A0);
         step();
      end
      idle();

      // 2: a stalled s1 grant holds the port while s0 waits
      s1_arvalid = 1; s1_araddr = A1; s1_arid = 6'h11;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin s0_arvalid = 1; s0_araddr = A0; s0_arid = 6'h22; end
         settle();
         chk("stall_araddr", m_araddr, A1);
         chk("stall_s0_arready", 64'(s0_arready), 64'd0);
         step();
      end
      m_arready = 1;
      settle();
      chk("stall_hs_s1_arready", 64'(s1_arready), 64'd1);
      chk("stall_hs_arid", 64'(m_arid), 64'h51);
      step();
      s1_arvalid = 0;
      settle();
      chk("after_stall_araddr", m_araddr, A0);
      chk("after_stall_s0_arready", 64'(s0_arready), 64'd1);
      step();
      idle();

      // 3: W order follows AW order; s1 W is held back until s0's burst ends
      m_awready = 1; m_wready = 1;
      s1_wvalid = 1; s1_wdata[63:0] = 64'd200;
      settle();
      chk("w_before_aw_s1_wready", 64'(s1_wready), 64'd0);
      chk("w_before_aw_m_wvalid", 64'(m_wvalid), 64'd0);
      s0_awvalid = 1; s0_awlen = 8'd3; s0_awid = 6'h03;
      settle();
      chk("aw0_awready", 64'(s0_awready), 64'd1);
      chk("aw0_awid", 64'(m_awid), 64'h03);
      step();
      s0_awvalid = 0;
      s1_awvalid = 1; s1_awlen = 8'd1; s1_awid = 6'h04;
      settle();
      chk("aw1_awready", 64'(s1_awready), 64'd1);
      chk("aw1_awid", 64'(m_awid), 64'h44);
      chk("aw1_s1_wready", 64'(s1_wready), 64'd0);
      step();
      s1_awvalid = 0;
      for (int b = 0; b < 4; b++) begin
         s0_wvalid = 1; s0_wdata[63:0] = 64'(100 + b); s0_wlast = (b == 3);
         settle();
         chk("w0_s0_wready", 64'(s0_wready), 64'd1);
         chk("w0_s1_wready", 64'(s1_wready), 64'd0);
         chk("w0_wdata", m_wdata[63:0], 64'(100 + b));
         step();
      end
      s0_wvalid = 0; s0_wlast = 0;
      for (int b = 0; b < 2; b++) begin
         s1_wdata[63:0] = 64'(200 + b); s1_wlast = (b == 1);
         settle();
         chk("w1_s1_wready", 64'(s1_wready), 64'd1);
         chk("w1_wdata", m_wdata[63:0], 64'(200 + b));
         chk("w1_wlast", 64'(m_wlast), 64'(b));
         step();
      end
      settle();
      chk("w_drained_m_wvalid", 64'(m_wvalid), 64'd0);
      chk("w_drained_s1_wready", 64'(s1_wready), 64'd0);
      idle();

      // 4: FIFO full blocks the fifth AW, including in the cycle of a pop
      m_awready = 1;
      s0_awvalid = 1;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("fill_awready", 64'(s0_awready), 64'd1);
         step();
      end
      settle();
      chk("full_awready", 64'(s0_awready), 64'd0);
      chk("full_m_awvalid", 64'(m_awvalid), 64'd0);
      step();
      s0_wvalid = 1; s0_wlast = 1; m_wready = 1;
      settle();
      chk("full_pop_m_wvalid", 64'(m_wvalid), 64'd1);
      chk("full_pop_awready", 64'(s0_awready), 64'd0);
      step();
      m_wready = 0;
      settle();
      chk("after_pop_awready", 64'(s0_awready), 64'd1);
      step();
      s0_awvalid = 0;
      m_wready = 1;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("drain_s0_wready", 64'(s0_wready), 64'd1);
         step();
      end
      settle();
      chk("drain_empty_m_wvalid", 64'(m_wvalid), 64'd0);
      idle();

      // 5: R and B routing table
      m_rdata[63:0] = 64'hdead_beef_0123_4567;
      for (int i = 0; i < 6; i++) begin
         m_rvalid = tbl[i].valid; m_rid = tbl[i].id;
         s0_rready = tbl[i].rdy0; s1_rready = tbl[i].rdy1;
         m_bvalid = tbl[i].valid; m_bid = tbl[i].id;
         s0_bready = tbl[i].rdy0; s1_bready = tbl[i].rdy1;
         settle();
         chk("tbl_s0_rvalid", 64'(s0_rvalid), 64'(tbl[i].e_v0));
         chk("tbl_s1_rvalid", 64'(s1_rvalid), 64'(tbl[i].e_v1));
         chk("tbl_s1_rid", 64'(s1_rid), 64'(tbl[i].e_id));
         chk("tbl_m_rready", 64'(m_rready), 64'(tbl[i].e_mrdy));
         chk("tbl_s0_bvalid", 64'(s0_bvalid), 64'(tbl[i].e_v0));
         chk("tbl_s1_bvalid", 64'(s1_bvalid), 64'(tbl[i].e_v1));
         chk("tbl_s0_bid", 64'(s0_bid), 64'(tbl[i].e_id));
         chk("tbl_m_bready", 64'(m_bready), 64'(tbl[i].e_mrdy));
         step();
      end
      chk("r_data_bcast", s1_rdata[63:0], 64'hdead_beef_0123_4567);
      idle();

      // 6: reset in the middle of a W burst
      s0_arvalid = 1; m_arready = 1;
      settle();
      chk("pre_rst_s0_arready", 64'(s0_arready), 64'd1);
      step();
      s0_arvalid = 0;
      s0_awvalid = 1; s0_awlen = 8'd3; m_awready = 1;
      step();
      s0_awvalid = 0;
      s0_wvalid = 1; m_wready = 1;
      step(); step();
      aresetn = 0;
      s0_arvalid = 1; s1_arvalid = 1; s0_awvalid = 1;
      m_rvalid = 1; m_rid = 7'h00; m_bvalid = 1; m_bid = 7'h40;
      settle();
      chk("mid_rst_m_arvalid", 64'(m_arvalid), 64'd0);
      chk("mid_rst_m_awvalid", 64'(m_awvalid), 64'd0);
      chk("mid_rst_m_wvalid", 64'(m_wvalid), 64'd0);
      chk("mid_rst_s0_rvalid", 64'(s0_rvalid), 64'd0);
      chk("mid_rst_s1_bvalid", 64'(s1_bvalid), 64'd0);
      step();
      aresetn = 1;
      s0_awvalid = 0; m_rvalid = 0; m_bvalid = 0;
      s1_arid = 6'h2a; s1_araddr = A1;
      settle();
      chk("post_rst_fifo_empty", 64'(m_wvalid), 64'd0);
      chk("post_rst_prio0", 64'(m_arid[6]), 64'd0);
      step();
      s0_arvalid = 0;
      settle();
      chk("post_rst_s1_arvalid", 64'(m_arvalid), 64'd1);
      chk("post_rst_s1_arid", 64'(m_arid), 64'h6a);
      chk("post_rst_s1_arready", 64'(s1_arready), 64'd1);
      step();
      s1_arvalid = 0;
      m_rvalid = 1; m_rid = 7'h6a; m_rlast = 1; s1_rready = 1;
      settle();
      chk("post_rst_s1_rvalid", 64'(s1_rvalid), 64'd1);
      chk("post_rst_s0_rvalid", 64'(s0_rvalid), 64'd0);
      chk("post_rst_m_rready", 64'(m_rready), 64'd1);
      chk("post_rst_s1_rid", 64'(s1_rid), 64'h2a);
      step();
      idle();

      // randomized AR traffic plus R/B routing, against a transaction-level model
      aresetn = 0;
      step(); step();
      aresetn = 1;
      act[0] = 0; act[1] = 0;
      last_served = 1;
      committed = -1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int m = 0; m < 2; m++) begin
            if (!act[m] && $urandom_range(0, 1) == 1) begin
               act[m] = 1;
               raddr[m] = {$urandom, $urandom};
               rid_q[m] = 6'($urandom_range(0, 63));
            end
         end
         s0_arvalid = act[0]; s0_araddr = raddr[0]; s0_arid = rid_q[0];
         s1_arvalid = act[1]; s1_araddr = raddr[1]; s1_arid = rid_q[1];
         m_arready = 1'($urandom_range(0, 1));
         rnd_id = 7'($urandom_range(0, 127));
         m_rvalid = 1'($urandom_range(0, 1)); m_rid = rnd_id;
         s0_rready = 1'($urandom_range(0, 1)); s1_rready = 1'($urandom_range(0, 1));
         m_bvalid = 1'($urandom_range(0, 1)); m_bid = ~rnd_id;
         s0_bready = 1'($urandom_range(0, 1)); s1_bready = 1'($urandom_range(0, 1));
         settle();

         // a presented-but-unaccepted request keeps the port; otherwise alternate on contention
         if (committed >= 0) win = committed;
         else if (act[0] && act[1]) win = 1 - last_served;
         else if (act[0]) win = 0;
         else if (act[1]) win = 1;
         else win = -1;

         chk("rnd_m_arvalid", 64'(m_arvalid), 64'(win >= 0));
         if (win >= 0) begin
            chk("rnd_araddr", m_araddr, raddr[win]);
            chk("rnd_arid", 64'(m_arid), 64'({1'(win), rid_q[win]}));
         end
         chk("rnd_s0_arready", 64'(s0_arready), 64'(win == 0 && m_arready));
         chk("rnd_s1_arready", 64'(s1_arready), 64'(win == 1 && m_arready));
         chk("rnd_s0_rvalid", 64'(s0_rvalid), 64'(m_rvalid && rnd_id < 7'd64));
         chk("rnd_s1_rvalid", 64'(s1_rvalid), 64'(m_rvalid && rnd_id >= 7'd64));
         chk("rnd_s0_rid", 64'(s0_rid), 64'(rnd_id % 64));
         chk("rnd_m_rready", 64'(m_rready), 64'(rnd_id >= 7'd64 ? s1_rready : s0_rready));
         chk("rnd_s1_bvalid", 64'(s1_bvalid), 64'(m_bvalid && rnd_id < 7'd64));
         chk("rnd_m_bready", 64'(m_bready), 64'(rnd_id < 7'd64 ? s1_bready : s0_bready));

         if (win >= 0) begin
            if (m_arready) begin
               act[win] = 0;
               last_served = win;
               committed = -1;
            end else begin
               committed = win;
            end
         end
         step();
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
